cache_line_adapter: RTL

- Memory-side responder for the cache controller's line-transfer interface; the controller is the initiator.
- Accepts single-cycle `cl_read` / `cl_write` requests and returns `cl_busy`.
- Converts each request into a burst of word transactions on a word-wide main-memory bus: writebacks serialise a full line out; refills gather a full line in.
- Sits between the cache data/tag arrays and the main-memory port.

---
 rtl/cache_line_adapter.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/cache_line_adapter.sv
// cache_line_adapter: memory-side responder for the cache line-transfer port.
// A cl_write pulse serialises a victim line into word writes on the memory
// bus; a cl_read pulse gathers a line from word reads; both together run the
// writeback first and the refill straight after it.
// Optional feature macro: CL_TIMEOUT_EN adds a per-word ack watchdog that
// abandons a stalled burst and raises the sticky cl_err flag.
module cache_line_adapter #(
    parameter int WORDS_PER_LINE = 8,
    parameter int WORD_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             cl_read,
    input  logic                             cl_write,
    input  logic [ADDR_W-1:0]                cl_rd_addr,
    input  logic [ADDR_W-1:0]                cl_wb_addr,
    input  logic [WORDS_PER_LINE*WORD_W-1:0] cl_wline,
    output logic [WORDS_PER_LINE*WORD_W-1:0] cl_rline,
    output logic                             cl_busy,
    output logic                             cl_err,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic                             mem_rden,
    output logic                             mem_wren,
    output logic [WORD_W-1:0]                mem_wdata,
    input  logic [WORD_W-1:0]                mem_rdata,
    input  logic                             mem_ack
);

    localparam int LINE_W   = WORDS_PER_LINE * WORD_W;
    localparam int CNT_W    = $clog2(WORDS_PER_LINE);
    localparam int WBYTE_SH = $clog2(WORD_W / 8);

    localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(WORDS_PER_LINE * (WORD_W / 8));
    // Clears the in-line offset bits so an address points at its line base.
    localparam logic [ADDR_W-1:0] LINE_MASK  = ~(LINE_BYTES - ADDR_W'(1));
    localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(WORDS_PER_LINE - 1);

    // Parameter sanity checks, evaluated at elaboration.
    if (WORDS_PER_LINE < 2 || (WORDS_PER_LINE & (WORDS_PER_LINE - 1)) != 0) begin : g_bad_wpl
        $error("cache_line_adapter: WORDS_PER_LINE must be a power of two, at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cache_line_adapter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    // Control state
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;

    // Request context captured on the accept edge
    logic [ADDR_W-1:0]  wb_base_q, wb_base_d;
    logic [ADDR_W-1:0]  rd_base_q, rd_base_d;
    logic [LINE_W-1:0]  wline_q, wline_d;

    // Registered outputs
    logic [LINE_W-1:0]  rline_q, rline_d;
    logic               busy_q, busy_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               rden_q, rden_d;
    logic               wren_q, wren_d;
    logic [WORD_W-1:0]  wdata_q, wdata_d;

`ifdef CL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               err_q, err_d;
`endif

    // Byte address of word idx inside the line at base; the offset never
    // carries into the tag because base has its offset bits cleared.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  idx);
        word_addr = base | (ADDR_W'(idx) << WBYTE_SH);
    endfunction

    // Next-state, burst sequencing and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        wb_base_d = wb_base_q;
        rd_base_d = rd_base_q;
        wline_d   = wline_q;
        rline_d   = rline_q;
`ifdef CL_TIMEOUT_EN
        wdog_d    = '0;
        err_d     = err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (cl_write) begin
                    state_d   = S_WB;
                    cnt_d     = '0;
                    pend_d    = cl_read;
                    wb_base_d = cl_wb_addr & LINE_MASK;
                    rd_base_d = cl_rd_addr & LINE_MASK;
                    wline_d   = cl_wline;
                end else if (cl_read) begin
                    state_d   = S_RD;
                    cnt_d     = '0;
                    pend_d    = 1'b0;
                    rd_base_d = cl_rd_addr & LINE_MASK;
                end
            end
            S_WB: begin
                if (mem_ack) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d = '0;
                        if (pend_q) begin
                            // Chain straight into the refill; busy never drops.
                            state_d = S_RD;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_RD: begin
                if (mem_ack) begin
                    rline_d[cnt_q*WORD_W +: WORD_W] = mem_rdata;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase

`ifdef CL_TIMEOUT_EN
        // A request is outstanding whenever the FSM is in a burst state.
        if (state_q != S_IDLE && !mem_ack) begin
            wdog_d = wdog_q + 1'b1;
            if (wdog_d == WD_W'(TIMEOUT_CYCLES)) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
                err_d   = 1'b1;
                wdog_d  = '0;
            end
        end
`endif

        // Outputs follow the next state so they appear registered on the
        // same edge the state advances.
        busy_d  = (state_d != S_IDLE);
        rden_d  = (state_d == S_RD);
        wren_d  = (state_d == S_WB);
        addr_d  = '0;
        wdata_d = '0;
        if (state_d == S_WB) begin
            addr_d  = word_addr(wb_base_d, cnt_d);
            wdata_d = wline_d[cnt_d*WORD_W +: WORD_W];
        end else if (state_d == S_RD) begin
            addr_d  = word_addr(rd_base_d, cnt_d);
        end
    end

    // Control state and all visible outputs; reset aborts any burst at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            rline_q <= '0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            rden_q  <= 1'b0;
            wren_q  <= 1'b0;
            wdata_q <= '0;
`ifdef CL_TIMEOUT_EN
            wdog_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            rline_q <= rline_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            rden_q  <= rden_d;
            wren_q  <= wren_d;
            wdata_q <= wdata_d;
`ifdef CL_TIMEOUT_EN
            wdog_q  <= wdog_d;
            err_q   <= err_d;
`endif
        end
    end

    // Captured request context; only meaningful while a burst runs.
    always_ff @(posedge CLK) begin
        wb_base_q <= wb_base_d;
        rd_base_q <= rd_base_d;
        wline_q   <= wline_d;
    end

    assign cl_rline  = rline_q;
    assign cl_busy   = busy_q;
    assign mem_addr  = addr_q;
    assign mem_rden  = rden_q;
    assign mem_wren  = wren_q;
    assign mem_wdata = wdata_q;
`ifdef CL_TIMEOUT_EN
    assign cl_err    = err_q;
`else
    assign cl_err    = 1'b0;
`endif

endmodule
